// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Define PS2_TX_RETRY_EN to re-send a failed byte up to RETRIES times.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int RETRIES        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] E_NACK = 2'b01;
  localparam logic [1:0] E_TMO  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_EDGE,
    ACK,
    RECOVER
  } state_t;

  state_t state, state_nx;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          sync_clk;
  logic          sync_data;
  logic          fall;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          drv_data;
  logic          nack;
  logic [1:0]    err_code_q;
  logic          accept;
  logic          tmo;
  logic          lines_up;
  logic          fail;
  logic [1:0]    fail_code;
  logic          can_retry;

  assign sync_clk  = clk_sync[1];
  assign sync_data = data_sync[1];
  assign fall      = clk_prev & ~sync_clk;
  assign lines_up  = sync_clk & sync_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= sync_clk;
    end
  end

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid & tx_ready;

  // Idle timeout is only meaningful while the device owns the clock.
  assign tmo = ((state == WAIT_EDGE) || (state == RECOVER))
             && !fall && (to_cnt == TMO_LAST);

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

  logic [RW-1:0] retry_cnt;

  assign can_retry = (retry_cnt < RETRY_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
    end else if (fail && can_retry) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  logic unused_retries;

  assign can_retry      = 1'b0;
  assign unused_retries = ^RETRIES;
`endif

  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    fail      = 1'b0;
    fail_code = E_NACK;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = INHIBIT;
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) state_nx = RTS;
      end
      RTS: begin
        state_nx = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_TMO;
        end else if (fall && bit_cnt == 4'd10) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = RECOVER;
      end
      RECOVER: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_TMO;
        end else if (lines_up) begin
          if (nack) begin
            fail = 1'b1;
          end else begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (fail) state_nx = can_retry ? INHIBIT : IDLE;
  end

  assign err      = fail & ~can_retry;
  assign busy     = (state != IDLE) & ~done & ~err;
  assign err_code = err ? fail_code : err_code_q;

  assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
  assign ps2_data_oe = (state == RTS)
                     || ((state == WAIT_EDGE) && drv_data && !tmo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      drv_data   <= 1'b0;
      nack       <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state <= state_nx;
      if (err) err_code_q <= fail_code;
      if (accept) shreg <= {1'b1, ~^tx_data, tx_data};
      if (state_nx == INHIBIT && state != INHIBIT) begin
        inh_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == INHIBIT) begin
        inh_cnt <= inh_cnt + 1'b1;
      end
      if (state == RTS) begin
        to_cnt   <= '0;
        drv_data <= 1'b1;
      end else if (state == WAIT_EDGE
                || state == ACK
                || state == RECOVER) begin
        to_cnt <= fall ? '0 : to_cnt + 1'b1;
      end
      // Host updates data after each device falling edge.
      if (state == WAIT_EDGE && fall) begin
        if (bit_cnt < 4'd10) begin
          drv_data <= ~shreg[bit_cnt];
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          nack <= sync_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a cycle-level PS/2 device model.
// Expected outcomes come from a transaction-level model of the protocol.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH    = 20;
  localparam int TMO    = 200;
  localparam int NRETRY = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int R = NRETRY;
`else
  localparam int R = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .RETRIES(NRETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code)
  );

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic [9:0] bits;
    logic       chk_bits;
    int         attempts;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   resp_cnt = 0;

  int         dev_nacks = 0;
  bit         dev_silent = 1'b0;
  int         dev_attempts = 0;
  int         dev_bitno = 0;
  logic [9:0] dev_bits = '0;
  bit         dev_idle = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Frame is d0..d7, odd parity, stop; retries extend the attempt count.
  function automatic exp_t model(logic [7:0] b, int nacks, bit silent);
    exp_t e;
    int   ones;
    ones = $countones(b);
    for (int i = 0; i < 8; i++) e.bits[i] = b[i];
    e.bits[8]  = (ones % 2 == 0);
    e.bits[9]  = 1'b1;
    e.chk_bits = !silent;
    if (silent) begin
      e.is_err   = 1'b1;
      e.code     = 2'b10;
      e.attempts = R + 1;
    end else if (nacks <= R) begin
      e.is_err   = 1'b0;
      e.code     = 2'b00;
      e.attempts = nacks + 1;
    end else begin
      e.is_err   = 1'b1;
      e.code     = 2'b01;
      e.attempts = R + 1;
    end
    return e;
  endfunction

  initial begin : device
    int n;
    bit nack;
    forever begin
      dev_idle = 1'b1;
      do @(negedge clk); while (!ps2_clk_oe);
      dev_idle = 1'b0;
      dev_attempts++;
      dev_bitno = 0;
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < 10000) begin
        n++;
        @(negedge clk);
      end
      check("inhibit_len", n, INH);
      n = 0;
      while (ps2_clk_oe && ps2_data_oe && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("rts_len", n, 1);
      if (dev_silent) begin
        n = 0;
        while (ps2_data_oe && !ps2_clk_oe && n < 1000) begin
          n++;
          @(negedge clk);
        end
        checks++;
        if (n < TMO - 2 || n > TMO) begin
          errors++;
          $display("FAIL release_after_rts: got %0d cycles want %0d..%0d",
                   n, TMO - 2, TMO);
        end
      end else begin
        nack = (dev_attempts <= dev_nacks);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
          if (i == 10 && !nack) begin
            dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
          end
          dev_clk_low = 1'b1;
          repeat (20) @(negedge clk);
          if (i < 10) begin
            dev_bits[i] = ps2_data_i;
            dev_bitno++;
          end
          dev_clk_low  = 1'b0;
          dev_data_low = 1'b0;
          if (i < 10) repeat (20) @(negedge clk);
        end
      end
    end
  end

  bit prev_busy = 1'b0;
  bit chk_ready = 1'b0;

  always @(negedge clk) begin
    if (chk_ready) begin
      check("ready_after_pulse", tx_ready, 1);
      chk_ready = 1'b0;
    end
    if (done || err) begin
      check("done_err_exclusive", done & err, 0);
      check("busy_before_pulse", prev_busy, 1);
      check("busy_with_pulse", busy, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b want none",
                 done, err);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_is_err", err, mon_e.is_err);
        if (mon_e.is_err) check("err_code", err_code, mon_e.code);
        if (mon_e.chk_bits) check("frame_bits", dev_bits, mon_e.bits);
        check("attempts", dev_attempts, mon_e.attempts);
      end
      resp_cnt++;
      chk_ready = 1'b1;
    end
    prev_busy = busy;
  end

  task automatic send(logic [7:0] b, int nacks, bit silent, bit push);
    int w;
    w = 0;
    while ((!dev_idle || !tx_ready) && w < 5000) begin
      w++;
      @(negedge clk);
    end
    dev_nacks    = nacks;
    dev_silent   = silent;
    dev_attempts = 0;
    if (push) exp_q.push_back(model(b, nacks, silent));
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    repeat (3) begin
      check("busy_after_accept", busy, 1);
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_resp(int target);
    int w;
    w = 0;
    while (resp_cnt < target && w < 20000) begin
      w++;
      @(negedge clk);
    end
    if (resp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses want %0d",
               resp_cnt, target);
      exp_q.delete();
    end
  endtask

  initial begin : stim
    int  n;
    int  w;
    int  sel;
    int  nk;
    bit  sil;
    logic [7:0] b;
    n = 0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_err_code", err_code, 0);

    send(8'hED, 0, 1'b0, 1'b1);
    wait_resp(++n);
    send(8'h01, 0, 1'b0, 1'b1);
    wait_resp(++n);
    send(8'hFF, 99, 1'b0, 1'b1);
    wait_resp(++n);
    send(8'hF4, 0, 1'b1, 1'b1);
    wait_resp(++n);

    send(8'hED, 0, 1'b0, 1'b0);
    w = 0;
    while (dev_bitno < 4 && w < 5000) begin
      w++;
      @(negedge clk);
    end
    check("reached_bit4", dev_bitno >= 4, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_clk_oe", ps2_clk_oe, 0);
    check("async_rst_data_oe", ps2_data_oe, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tx_ready, 1);
    check("post_rst_busy", busy, 0);
    send(8'h01, 0, 1'b0, 1'b1);
    wait_resp(++n);

`ifdef PS2_TX_RETRY_EN
    send(8'hED, 2, 1'b0, 1'b1);
    wait_resp(++n);
`endif

    for (int i = 0; i < 10; i++) begin
      b   = 8'($urandom);
      sel = $urandom_range(0, 3);
      sil = (sel == 0);
      nk  = (sel == 1) ? $urandom_range(1, 3) : 0;
      send(b, nk, sil, 1'b1);
      wait_resp(++n);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
